// File: rtl/load_store_unit_if.sv
// Request/response and memory-port bundle for the load/store unit.
// slave = the load/store unit, master = the requester plus memory.
interface load_store_unit_if;
  localparam int N = 32;

  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [2:0]   req_funct3;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic         rsp_valid;
  logic [N-1:0] rsp_rdata;
  logic         rsp_misaligned;
  logic         mem_wr_ena;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_din;
  logic [N-1:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
           mem_wr_ena, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
           mem_wr_ena, mem_addr, mem_din
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores (RISC-V funct3) against a
// word-wide synchronous memory port. Sub-word stores are read-modify-write.
module load_store_unit (
  input  logic              clk,
  input  logic              rstb,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, WRITE, RESP} state_t;

  state_t      state;
  state_t      next_state;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] merge_q;

  logic        accept;
  logic        req_err;
  logic        is_sw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign accept = (state == IDLE) && bus.req_valid;
  assign is_sw  = we_q && (funct3_q == 3'b010);

  // Reject illegal encodings, stores of unsigned widths and misaligned H/W.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = |bus.req_addr[1:0];
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  // Pick the addressed byte and half out of the word just read.
  always_comb begin
    byte_sel = bus.mem_dout[7:0];
    case (addr_q[1:0])
      2'd0: byte_sel = bus.mem_dout[7:0];
      2'd1: byte_sel = bus.mem_dout[15:8];
      2'd2: byte_sel = bus.mem_dout[23:16];
      2'd3: byte_sel = bus.mem_dout[31:24];
    endcase
    half_sel = addr_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
  end

  // Extend the selected lane according to the load width and signedness.
  always_comb begin
    load_val = bus.mem_dout;
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = bus.mem_dout;
    endcase
  end

  // Splice the store data into the read word for SB/SH.
  always_comb begin
    merge_val = bus.mem_dout;
    if (funct3_q == 3'b000) begin
      case (addr_q[1:0])
        2'd0: merge_val[7:0]   = wdata_q[7:0];
        2'd1: merge_val[15:8]  = wdata_q[7:0];
        2'd2: merge_val[23:16] = wdata_q[7:0];
        2'd3: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q[15:0];
    end else begin
      merge_val[15:0] = wdata_q[15:0];
    end
  end

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= next_state;
  end

  // Sequencing: error -> RESP, SW -> one write, loads wait one cycle, SB/SH add a write.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = req_err ? RESP : ACCESS;
      ACCESS:  next_state = is_sw ? RESP : WAIT;
      WAIT:    next_state = we_q ? WRITE : RESP;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, load result and merged store word.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      merge_q  <= 32'h0;
    end else if (accept) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      err_q    <= req_err;
      rdata_q  <= 32'h0;
    end else if (state == WAIT) begin
      if (we_q) merge_q <= merge_val;
      else      rdata_q <= load_val;
    end
  end

  // Outputs decoded from state; writes only in ACCESS (SW) or WRITE.
  always_comb begin
    bus.req_ready      = (state == IDLE) && rstb;
    bus.mem_wr_ena     = ((state == ACCESS) && is_sw) || (state == WRITE);
    bus.mem_addr       = {addr_q[31:2], 2'b00};
    bus.mem_din        = (state == ACCESS) ? wdata_q : merge_q;
    bus.rsp_valid      = (state == RESP);
    bus.rsp_misaligned = (state == RESP) && err_q;
    bus.rsp_rdata      = rdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  // Synchronous-read memory standing in for the dual-port RAM, port 1.
  logic [31:0] tb_mem [0:255] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_wr_ena) tb_mem[bus.mem_addr[9:2]] <= bus.mem_din;
    bus.mem_dout <= tb_mem[bus.mem_addr[9:2]];
  end

  logic [31:0] ref_mem [0:255];

  int checks = 0;
  int errors = 0;

  int          obs_rsp_cycle;
  logic [31:0] obs_rdata;
  logic        obs_mis;
  int          obs_wr_count;
  int          obs_wr_cycle;
  logic [31:0] obs_wr_addr;
  logic [31:0] obs_wr_din;
  int          obs_busy_ready;
  logic        obs_after_valid;
  logic        obs_after_ready;
  logic        obs_after_wr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request, then record everything the unit does until one cycle past the response.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int waited;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    waited = 0;
    while (!bus.req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    obs_rsp_cycle  = 0;
    obs_rdata      = 32'h0;
    obs_mis        = 1'b0;
    obs_wr_count   = 0;
    obs_wr_cycle   = 0;
    obs_wr_addr    = 32'h0;
    obs_wr_din     = 32'h0;
    obs_busy_ready = 0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8 && obs_rsp_cycle == 0; c++) begin
      @(negedge clk);
      if (bus.req_ready) obs_busy_ready++;
      if (bus.mem_wr_ena) begin
        obs_wr_count++;
        obs_wr_cycle = c;
        obs_wr_addr  = bus.mem_addr;
        obs_wr_din   = bus.mem_din;
      end
      if (bus.rsp_valid) begin
        obs_rsp_cycle = c;
        obs_rdata     = bus.rsp_rdata;
        obs_mis       = bus.rsp_misaligned;
      end
    end
    @(negedge clk);
    obs_after_valid = bus.rsp_valid;
    obs_after_ready = bus.req_ready;
    obs_after_wr    = bus.mem_wr_ena;
  endtask

  // Reference behaviour from the architectural rules, then compare.
  task automatic runTxn(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned idx, k, old_w, b, h, new_w, load_v, exp_rdata, exp_cycle, exp_wr_cycle;
    bit err, legal, writes;
    idx   = (addr / 4) % 256;
    k     = addr % 4;
    old_w = ref_mem[idx];
    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    err   = !legal || (we && f3 >= 4) ||
            ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) ||
            (f3 == 2 && (addr % 4 != 0));
    b = (old_w >> (8 * k)) % 256;
    h = (old_w >> (16 * (k / 2))) % 65536;
    case (f3)
      3'd0:    load_v = (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    load_v = b;
      3'd1:    load_v = (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    load_v = h;
      default: load_v = old_w;
    endcase
    new_w = old_w;
    if (f3 == 2)      new_w = wdata;
    else if (f3 == 0) new_w = (old_w & ~(32'hFF << (8 * k))) | ((wdata % 256) << (8 * k));
    else if (f3 == 1) new_w = (old_w & ~(32'hFFFF << (16 * (k / 2)))) | ((wdata % 65536) << (16 * (k / 2)));
    writes       = !err && we;
    exp_rdata    = (err || we) ? 0 : load_v;
    exp_cycle    = err ? 1 : (we && f3 == 2) ? 2 : we ? 4 : 3;
    exp_wr_cycle = (f3 == 2) ? 1 : 3;
    if (writes) ref_mem[idx] = new_w;

    applyStimulus(we, f3, addr, wdata);

    checkOutput({tag, " rsp_cycle"}, obs_rsp_cycle, exp_cycle);
    checkOutput({tag, " rdata"}, obs_rdata, exp_rdata);
    checkOutput({tag, " misaligned"}, {31'h0, obs_mis}, {31'h0, err});
    checkOutput({tag, " wr_count"}, obs_wr_count, writes ? 1 : 0);
    if (writes) begin
      checkOutput({tag, " wr_cycle"}, obs_wr_cycle, exp_wr_cycle);
      checkOutput({tag, " wr_addr"}, obs_wr_addr, addr & 32'hFFFFFFFC);
      checkOutput({tag, " wr_din"}, obs_wr_din, new_w);
    end
    checkOutput({tag, " ready_while_busy"}, obs_busy_ready, 0);
    checkOutput({tag, " valid_after"}, {31'h0, obs_after_valid}, 32'h0);
    checkOutput({tag, " wr_after"}, {31'h0, obs_after_wr}, 32'h0);
    checkOutput({tag, " ready_after"}, {31'h0, obs_after_ready}, 32'h1);
    checkOutput({tag, " mem_word"}, tb_mem[idx], ref_mem[idx]);
  endtask

  int abort_wr;
  int abort_rsp;
  int abort_ready;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    // Power-on reset: three cycles low.
    rstb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset ready", {31'h0, bus.req_ready}, 32'h0);
    end
    checkOutput("reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    checkOutput("reset wr_ena", {31'h0, bus.mem_wr_ena}, 32'h0);
    checkOutput("reset mem_addr", bus.mem_addr, 32'h0);
    checkOutput("reset mem_din", bus.mem_din, 32'h0);
    checkOutput("reset rdata", bus.rsp_rdata, 32'h0);
    rstb = 1'b1;
    @(negedge clk);
    checkOutput("post-reset ready", {31'h0, bus.req_ready}, 32'h1);

    // Directed sequence.
    runTxn("SW 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    checkOutput("SW 0x10 spec din", obs_wr_din, 32'hDEADBEEF);
    runTxn("LW 0x10", 1'b0, 3'b010, 32'h10, 32'h0);
    checkOutput("LW 0x10 spec", obs_rdata, 32'hDEADBEEF);
    runTxn("SB 0x11", 1'b1, 3'b000, 32'h11, 32'h00000080);
    checkOutput("SB 0x11 spec din", obs_wr_din, 32'hDEAD80EF);
    runTxn("LB 0x11", 1'b0, 3'b000, 32'h11, 32'h0);
    checkOutput("LB 0x11 spec", obs_rdata, 32'hFFFFFF80);
    runTxn("LBU 0x11", 1'b0, 3'b100, 32'h11, 32'h0);
    checkOutput("LBU 0x11 spec", obs_rdata, 32'h00000080);
    runTxn("SH 0x12", 1'b1, 3'b001, 32'h12, 32'h00001234);
    checkOutput("SH 0x12 spec din", obs_wr_din, 32'h123480EF);
    runTxn("LH 0x12", 1'b0, 3'b001, 32'h12, 32'h0);
    checkOutput("LH 0x12 spec", obs_rdata, 32'h00001234);
    runTxn("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'h0);
    checkOutput("LHU 0x10 spec", obs_rdata, 32'h000080EF);
    runTxn("LH 0x10", 1'b0, 3'b001, 32'h10, 32'h0);
    checkOutput("LH 0x10 spec", obs_rdata, 32'hFFFF80EF);
    runTxn("err LW 0x13", 1'b0, 3'b010, 32'h13, 32'h0);
    runTxn("err SH 0x11", 1'b1, 3'b001, 32'h11, 32'h5555);
    runTxn("err store f3=4", 1'b1, 3'b100, 32'h10, 32'h77);
    checkOutput("err word intact", tb_mem[4], 32'h123480EF);

    // Reset while SB 0x10 sits in its read-wait cycle.
    abort_wr = 0;
    abort_rsp = 0;
    abort_ready = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'hAA;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    if (bus.mem_wr_ena) abort_wr++;
    if (bus.rsp_valid) abort_rsp++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.req_ready) abort_ready++;
      if (bus.mem_wr_ena) abort_wr++;
      if (bus.rsp_valid) abort_rsp++;
    end
    rstb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_wr_ena) abort_wr++;
      if (bus.rsp_valid) abort_rsp++;
    end
    checkOutput("abort wr pulses", abort_wr, 0);
    checkOutput("abort rsp pulses", abort_rsp, 0);
    checkOutput("abort ready in reset", abort_ready, 0);
    runTxn("LW 0x10 after abort", 1'b0, 3'b010, 32'h10, 32'h0);
    checkOutput("LW after abort spec", obs_rdata, 32'h123480EF);

    // Instruction-region address aliases to the same memory word.
    runTxn("LW 0x40000010", 1'b0, 3'b010, 32'h40000010, 32'h0);

    // Randomized traffic over a small set of words.
    for (int n = 0; n < 120; n++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      logic [31:0] r_wdata;
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r_addr = r_addr | 32'h40000000;
      if ($urandom_range(0, 2) != 0 && r_f3 == 3'b010) r_addr = r_addr & 32'hFFFFFFFC;
      r_wdata = $urandom;
      runTxn($sformatf("rand%0d we=%0d f3=%0d a=%08h", n, r_we, r_f3, r_addr),
             r_we, r_f3, r_addr, r_wdata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Word-addressed memory front end for the CPU data path, sitting directly upstream of port 1 of the dual-port memory. It accepts byte, halfword and word load/store requests from the execute stage using RISC-V funct3 encoding. Sub-word stores are performed as a read-modify-write of the containing 32-bit word. Loads are returned sign- or zero-extended, and misaligned or illegal requests are rejected without touching memory.

## Interface
- N, 32, data/address bus width

- clk  in  1  system clock, all state on rising edge
- rstb  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request; 0 while rstb low
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- req_addr  in  N  byte address
- req_wdata  in  N  store data, right-aligned (low byte/half used for B/H)
- rsp_valid  out  1  one-cycle pulse, response complete
- rsp_rdata  out  N  extended load data; 0 for stores and errors
- rsp_misaligned  out  1  valid with rsp_valid: request rejected
- mem_wr_ena  out  1  to memory wr_ena1
- mem_addr  out  N  to memory addr1, always {addr[31:2],2'b00}
- mem_din  out  N  to memory din1
- mem_dout  in  N  from memory dout1; valid the cycle after mem_addr applied

## Operation
- FSM states: IDLE, ACCESS, WAIT, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch we, funct3, addr, wdata.
  - Error check: H with addr[0]=1, W with addr[1:0]!=0, funct3 in {011,110,111}, or store with funct3 in {100,101}. Error goes to RESP with rsp_misaligned=1 and no memory access.
  - Otherwise go to ACCESS.
- ACCESS: mem_addr = word address of the latched addr.
  - SW: mem_wr_ena=1, mem_din=wdata, then go to RESP.
  - Any load or SB/SH: mem_wr_ena=0, then go to WAIT.
- WAIT: capture mem_dout.
  - Load: select lane and extend into the rsp_rdata register, then go to RESP.
  - SB/SH: form the merged word into the mem_din register, then go to WRITE.
- Lane select:
  - Byte lane k = addr[1:0], bits [8k+7:8k].
  - Half lane = addr[1], bits [16h+15:16h].
  - B/H sign-extend; BU/HU zero-extend; W passes the word unchanged.
- Merge:
  - SB replaces byte lane k with wdata[7:0].
  - SH replaces half lane h with wdata[15:0].
  - All other bits keep the read value.
- WRITE: mem_wr_ena=1, mem_din=merged word, then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. There is no response backpressure; the consumer must take it that cycle.
- mem_wr_ena is high only in ACCESS (SW) or WRITE; never in IDLE/WAIT/RESP.
- Instruction-region addresses (0x400 in addr[31:20]) are handled identically; the memory decodes the region.

## Timing
- Request accepted at edge 0 (req_valid & req_ready). Edge k = k-th subsequent rising edge.
- rsp_valid high in cycle:
  - error: 1
  - SW: 2
  - loads: 3
  - SB/SH: 4
- Write commits at the edge ending ACCESS (SW) or WRITE (SB/SH).
- Throughput: next request is accepted in the cycle after RESP. req_ready=0 from ACCESS through RESP.
- Reset values: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, mem_wr_ena=0, mem_addr=0, mem_din=0; all latched request registers 0.
- Reset mid-operation:
  - Immediate return to IDLE. No further mem_wr_ena pulse and no rsp_valid for the aborted request.
  - A write already committed at a prior edge stands.
- req_valid while not ready is ignored; the requester holds it.
- Back-to-back store then load to the same word returns the new data, since the write commits before the load's ACCESS.

## Test plan
- Reset: hold rstb low 3 cycles, then release. Required: req_ready=0 during reset, then 1; rsp_valid=0, mem_wr_ena=0, mem_addr=0.
- SW 0x0000_0010 ← 0xDEADBEEF, then LW 0x10.
  - SW: mem_wr_ena one pulse in cycle 1 with mem_addr=0x10, mem_din=0xDEADBEEF; rsp_valid in cycle 2.
  - LW: rsp_rdata=0xDEADBEEF in cycle 3, rsp_misaligned=0.
- SB 0x11 ← 0x00000080 over 0xDEADBEEF.
  - Write in cycle 3 of 0xDEAD80EF.
  - LB 0x11 → 0xFFFFFF80; LBU 0x11 → 0x00000080.
- SH 0x12 ← 0x00001234.
  - Word becomes 0x123480EF.
  - LH 0x12 → 0x00001234; LHU 0x10 → 0x000080EF; LH 0x10 → 0xFFFF80EF.
- Errors:
  - LW 0x13, SH 0x11 and store funct3=100: each gives rsp_valid in cycle 1 with rsp_misaligned=1, rsp_rdata=0.
  - Never mem_wr_ena; memory word unchanged.
- Reset during WAIT of SB 0x10 ← 0xAA: no mem_wr_ena pulse and no rsp_valid. A subsequent LW 0x10 returns 0x123480EF.
